mem_inspect_reader: RTL and testbench

Initiator for the processor's inference read port. After a program run, it walks a programmed address range and drives `infer`/`infer_addr` into the ControlUnit. It captures each returned `infer_data` word and presents it, with its address, to the display or debug path. In auto mode it paces the scan with a dwell counter; in manual mode it advances one word per `step` press.

---
 rtl/mem_inspect_reader.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_inspect_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_inspect_reader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_inspect_reader
//  Purpose  : Walks a latched address range on the processor's inference read
//             port, captures each returned word and presents it with its
//             address on a display/debug path. The scan is paced either by a
//             dwell counter (auto) or by step-button edges (manual).
//
//  Ports    :
//    fast_clk    in   1       system clock, rising edge
//    rst         in   1       synchronous active-high reset
//    start       in   1       level; rising edge starts a scan (IDLE/DONE)
//    manual      in   1       1 = step mode, 0 = auto dwell mode
//    step        in   1       level; rising edge advances in manual HOLD
//    base_addr   in   ADDR_W  first address, latched on start
//    last_addr   in   ADDR_W  final address, latched on start
//    infer       out  1       read-port enable
//    infer_addr  out  ADDR_W  read address
//    infer_data  in   DATA_W  read data, valid READ_LAT cycles after address
//    word        out  DATA_W  last captured data
//    word_addr   out  ADDR_W  address of word
//    word_valid  out  1       one-cycle pulse per capture
//    busy        out  1       scan in progress (SETUP..HOLD)
//    done        out  1       scan finished (DONE)
//
//  Revision : 1.0  initial release
// ============================================================================
module mem_inspect_reader #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int DWELL    = 100_000_000
) (
    input  logic              fast_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              manual,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              infer,
    output logic [ADDR_W-1:0] infer_addr,
    input  logic [DATA_W-1:0] infer_data,
    output logic [DATA_W-1:0] word,
    output logic [ADDR_W-1:0] word_addr,
    output logic              word_valid,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------------
    // Counter geometry
    // ------------------------------------------------------------------------
    localparam int c_WAIT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int c_DWELL_W = $clog2(DWELL + 1);

    localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST = c_WAIT_W'(READ_LAT - 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_END = c_DWELL_W'(DWELL);
    localparam logic [c_DWELL_W-1:0] c_DWELL_ONE = c_DWELL_W'(1);
    localparam logic [ADDR_W-1:0]    c_ADDR_ONE  = ADDR_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic                 r_start_q;
    logic                 r_step_q;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_last;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [c_DWELL_W-1:0] r_dwell_cnt;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic w_start_edge;
    logic w_step_edge;
    logic w_load;
    logic w_advance;
    logic w_release;

    assign w_start_edge = start & ~r_start_q;
    assign w_step_edge  = step  & ~r_step_q;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_release    = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_edge) begin
                    w_load       = 1'b1;
                    w_state_next = S_SETUP;
                end
            end

            S_SETUP: begin
                w_state_next = S_WAIT;
            end

            S_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_next = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                w_state_next = S_HOLD;
            end

            S_HOLD: begin
                // The mode is re-sampled every HOLD cycle, so a mode switch
                // takes effect immediately. The dwell count includes the
                // HOLD entry cycle at count 0 and releases once it has
                // reached DWELL.
                if (manual) begin
                    w_release = w_step_edge;
                end else begin
                    w_release = (r_dwell_cnt >= c_DWELL_END);
                end

                if (w_release) begin
                    if (r_addr == r_last) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = S_SETUP;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state == S_SETUP)   || (r_state == S_WAIT) ||
                  (r_state == S_CAPTURE) || (r_state == S_HOLD);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            r_step_q    <= 1'b0;
            r_addr      <= '0;
            r_last      <= '0;
            r_wait_cnt  <= '0;
            r_dwell_cnt <= '0;
            infer       <= 1'b0;
            infer_addr  <= '0;
            word        <= '0;
            word_addr   <= '0;
            word_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_start_q  <= start;
            r_step_q   <= step;
            word_valid <= 1'b0;

            // Range is latched once; later changes on base/last are ignored.
            if (w_load) begin
                r_addr <= base_addr;
                r_last <= last_addr;
            end

            // Address wraps naturally modulo 2^ADDR_W.
            if (w_advance) begin
                r_addr <= r_addr + c_ADDR_ONE;
            end

            case (r_state)
                S_SETUP: begin
                    // infer is only ever set here and cleared on DONE entry,
                    // so it stays high across consecutive words.
                    infer      <= 1'b1;
                    infer_addr <= r_addr;
                    r_wait_cnt <= '0;
                end

                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                end

                S_CAPTURE: begin
                    word        <= infer_data;
                    word_addr   <= infer_addr;
                    word_valid  <= 1'b1;
                    r_dwell_cnt <= '0;
                end

                S_HOLD: begin
                    // Saturate so long manual waits cannot wrap the counter.
                    if (r_dwell_cnt < c_DWELL_END) begin
                        r_dwell_cnt <= r_dwell_cnt + c_DWELL_ONE;
                    end
                    if (w_state_next == S_DONE) begin
                        infer <= 1'b0;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_inspect_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_inspect_reader
//  Purpose  : Self-checking bench for mem_inspect_reader with a registered
//             memory stub (READ_LAT = 1) returning 32'hA5A50000 | address,
//             DWELL = 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_inspect_reader;

    localparam int c_ADDR_W = 10;
    localparam int c_DATA_W = 32;

    logic                fast_clk;
    logic                rst;
    logic                start;
    logic                manual;
    logic                step;
    logic [c_ADDR_W-1:0] base_addr;
    logic [c_ADDR_W-1:0] last_addr;
    logic                infer;
    logic [c_ADDR_W-1:0] infer_addr;
    logic [c_DATA_W-1:0] infer_data;
    logic [c_DATA_W-1:0] word;
    logic [c_ADDR_W-1:0] word_addr;
    logic                word_valid;
    logic                busy;
    logic                done;

    mem_inspect_reader #(
        .ADDR_W   (c_ADDR_W),
        .DATA_W   (c_DATA_W),
        .READ_LAT (1),
        .DWELL    (4)
    ) u_dut (
        .fast_clk   (fast_clk),
        .rst        (rst),
        .start      (start),
        .manual     (manual),
        .step       (step),
        .base_addr  (base_addr),
        .last_addr  (last_addr),
        .infer      (infer),
        .infer_addr (infer_addr),
        .infer_data (infer_data),
        .word       (word),
        .word_addr  (word_addr),
        .word_valid (word_valid),
        .busy       (busy),
        .done       (done)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    // One-cycle registered memory stub.
    always @(posedge fast_clk) begin
        infer_data <= 32'hA5A50000 | {22'd0, infer_addr};
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic wait_wv(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            tick();
            if (word_valid) found = 1'b1;
        end
    endtask

    // Scan vectors: inputs plus the hand-computed capture address list
    // (exp_addr[0] is the first capture).
    typedef struct packed {
        logic [9:0]      base;
        logic [9:0]      last;
        logic            disturb;
        logic [2:0]      n;
        logic [3:0][9:0] exp_addr;
    } scan_vec_t;

    // Auto scan: captures after 4 cycles, then every 8; DONE 5 cycles after
    // the last capture.
    task automatic run_scan(input scan_vec_t v, input int row);
        int cyc;
        int caps;
        int last_cap;
        bit seen_infer;
        bit infer_drop;
        string tag;

        tag        = $sformatf("row%0d", row);
        manual     = 1'b0;
        step       = 1'b0;
        base_addr  = v.base;
        last_addr  = v.last;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        // Range inputs are latched; changing them now must have no effect.
        base_addr  = 10'h155;
        last_addr  = 10'h2AA;
        cyc        = 1;
        caps       = 0;
        last_cap   = 0;
        seen_infer = 1'b0;
        infer_drop = 1'b0;

        while (!done && cyc < 200) begin
            if (v.disturb) begin
                start = (cyc == 6) || (cyc == 15);
                step  = (cyc % 3 == 0);
            end
            if (word_valid) begin
                if (caps < int'(v.n)) begin
                    check({tag, "_word"}, word, 32'hA5A50000 | {22'd0, v.exp_addr[caps]});
                    check({tag, "_word_addr"}, word_addr, v.exp_addr[caps]);
                end
                if (caps == 0) check({tag, "_first_latency"}, cyc, 4);
                else           check({tag, "_spacing"}, cyc - last_cap, 8);
                last_cap = cyc;
                caps++;
            end
            if (infer) seen_infer = 1'b1;
            else if (seen_infer) infer_drop = 1'b1;
            tick();
            cyc++;
        end
        start = 1'b0;
        step  = 1'b0;

        check({tag, "_timeout"}, cyc < 200, 1);
        check({tag, "_captures"}, caps, v.n);
        check({tag, "_done_delay"}, cyc - last_cap, 5);
        check({tag, "_infer_continuous"}, infer_drop, 0);
        check({tag, "_infer_off_done"}, infer, 0);
        check({tag, "_busy_off_done"}, busy, 0);
        check({tag, "_word_held"}, word, 32'hA5A50000 | {22'd0, v.exp_addr[v.n - 3'd1]});
    endtask

    scan_vec_t vecs [4];

    initial begin
        bit found;
        int cnt;

        vecs[0] = '{base: 10'd3,    last: 10'd5, disturb: 1'b0, n: 3'd3,
                    exp_addr: {10'd0, 10'd5, 10'd4, 10'd3}};
        vecs[1] = '{base: 10'd1022, last: 10'd1, disturb: 1'b0, n: 3'd4,
                    exp_addr: {10'd1, 10'd0, 10'd1023, 10'd1022}};
        vecs[2] = '{base: 10'd3,    last: 10'd5, disturb: 1'b1, n: 3'd3,
                    exp_addr: {10'd0, 10'd5, 10'd4, 10'd3}};
        vecs[3] = '{base: 10'd9,    last: 10'd9, disturb: 1'b0, n: 3'd1,
                    exp_addr: {10'd0, 10'd0, 10'd0, 10'd9}};

        rst       = 1'b1;
        start     = 1'b0;
        manual    = 1'b0;
        step      = 1'b0;
        base_addr = '0;
        last_addr = '0;
        repeat (3) tick();

        // Reset state
        check("rst_infer",      infer,      0);
        check("rst_infer_addr", infer_addr, 0);
        check("rst_word",       word,       0);
        check("rst_word_addr",  word_addr,  0);
        check("rst_word_valid", word_valid, 0);
        check("rst_busy",       busy,       0);
        check("rst_done",       done,       0);
        rst = 1'b0;
        tick();

        // Auto-mode scans from the vector table
        for (int i = 0; i < 4; i++) begin
            run_scan(vecs[i], i);
            repeat (2) tick();
        end

        // Manual mode, single word at address 7
        manual    = 1'b1;
        base_addr = 10'd7;
        last_addr = 10'd7;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_wv(20, found);
        check("man_capture_seen", found, 1);
        check("man_word",         word, 32'hA5A50007);
        check("man_word_addr",    word_addr, 7);
        repeat (10) tick();
        check("man_hold_busy",    busy, 1);
        check("man_hold_not_done", done, 0);
        step = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (word_valid) cnt++;
        end
        step = 1'b0;
        check("man_step_done",     done, 1);
        check("man_step_no_extra", cnt, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("man_restart_busy", busy, 1);
        wait_wv(20, found);
        check("man_reread_seen", found, 1);
        check("man_reread_word", word, 32'hA5A50007);
        check("man_reread_addr", word_addr, 7);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("man_reread_done", done, 1);

        // Reset in the middle of an auto scan (during HOLD of first word)
        manual    = 1'b0;
        base_addr = 10'd20;
        last_addr = 10'd30;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("mid_pre_word", word, 32'hA5A50014);
        check("mid_pre_infer", infer, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_infer", infer, 0);
        check("mid_rst_busy",  busy,  0);
        check("mid_rst_word",  word,  0);
        check("mid_rst_done",  done,  0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (word_valid) cnt++;
            tick();
        end
        check("mid_rst_no_valid", cnt, 0);
        check("mid_rst_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
